dm_lsu: RTL and testbench

Load/store unit for the SISC processor: the initiator side of the data memory interface. It accepts one load or store request at a time from the processor control path, drives the data memory address, data and write-enable lines with the required setup, pulse and hold sequencing, and returns load data or store completion. The data memory commits a store on the falling edge of `dm_we`, so this block owns generation of that edge.

---
 rtl/sisc_lsu_pkg.sv | 27 ++
 rtl/dm_lsu_fwd_buf.sv | 39 +++
 rtl/dm_lsu.sv | 166 ++++++++++++++++
 tb/tb_dm_lsu.sv | 211 +++++++++++++++++++++
 4 files changed

// File: rtl/sisc_lsu_pkg.sv
// Shared definitions for the SISC load/store unit: FSM state encoding,
// bus widths and default timing/limit parameters.
package sisc_lsu_pkg;

  localparam int unsigned ADDR_W = 16;
  localparam int unsigned DATA_W = 32;

  localparam int unsigned         DEF_RD_LAT    = 1;
  localparam int unsigned         DEF_WE_CYCLES = 1;
  localparam logic [ADDR_W-1:0]   DEF_MAX_ADDR  = 16'hFFFC;

  typedef enum logic [2:0] {
    IDLE,
    RD_WAIT,
    RD_CAP,
    WR_SETUP,
    WR_PULSE,
    WR_HOLD,
    ERR
  } lsu_state_e;

  function automatic logic addr_oob(input logic [ADDR_W-1:0] addr,
                                    input logic [ADDR_W-1:0] max_addr);
    return addr > max_addr;
  endfunction

endpackage

// File: rtl/dm_lsu_fwd_buf.sv
// One-entry last-store buffer with load-address hit compare; only the valid
// bit is reset so a cleared buffer can never produce a hit.
module dm_lsu_fwd_buf
  import sisc_lsu_pkg::*;
(
  input  logic              clk,
  input  logic              rst_f,
  input  logic              upd,
  input  logic [ADDR_W-1:0] upd_addr,
  input  logic [DATA_W-1:0] upd_data,
  input  logic [ADDR_W-1:0] lk_addr,
  output logic              hit,
  output logic [DATA_W-1:0] hit_data
);

  logic              vld_q, vld_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [DATA_W-1:0] data_q, data_d;

  always_comb begin
    vld_d  = vld_q | upd;
    addr_d = upd ? upd_addr : addr_q;
    data_d = upd ? upd_data : data_q;
  end

  always_ff @(posedge clk or negedge rst_f) begin
    if (!rst_f) vld_q <= 1'b0;
    else        vld_q <= vld_d;
  end

  always_ff @(posedge clk) begin
    addr_q <= addr_d;
    data_q <= data_d;
  end

  assign hit      = vld_q && (addr_q == lk_addr);
  assign hit_data = data_q;

endmodule

// File: rtl/dm_lsu.sv
// SISC data-memory load/store unit: sequences read latency and dm_we
// setup/pulse/hold. Optional store-to-load forwarding under DM_LSU_FWD_EN.
module dm_lsu
  import sisc_lsu_pkg::*;
#(
  parameter int unsigned       RD_LAT    = DEF_RD_LAT,
  parameter int unsigned       WE_CYCLES = DEF_WE_CYCLES,
  parameter logic [ADDR_W-1:0] MAX_ADDR  = DEF_MAX_ADDR
) (
  input  logic              clk,
  input  logic              rst_f,
  input  logic              req_valid,
  input  logic              req_we,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [DATA_W-1:0] req_wdata,
  output logic              req_ready,
  output logic              rsp_valid,
  output logic [DATA_W-1:0] rsp_data,
  output logic              wr_done,
  output logic              rsp_err,
  output logic [ADDR_W-1:0] read_addr,
  output logic [ADDR_W-1:0] write_addr,
  output logic [DATA_W-1:0] write_data,
  output logic              dm_we,
  input  logic [DATA_W-1:0] read_data
);

  lsu_state_e        state_q, state_d;
  logic [2:0]        cnt_q, cnt_d;
  logic              op_we_q, op_we_d;
  logic              fwd_q, fwd_d;
  logic              req_ready_q, req_ready_d;
  logic              rsp_valid_q, rsp_valid_d;
  logic              wr_done_q, wr_done_d;
  logic              rsp_err_q, rsp_err_d;
  logic              dm_we_q, dm_we_d;
  logic [DATA_W-1:0] rsp_data_q, rsp_data_d;
  logic [ADDR_W-1:0] read_addr_q, read_addr_d;
  logic [ADDR_W-1:0] write_addr_q, write_addr_d;
  logic [DATA_W-1:0] write_data_q, write_data_d;
  logic              accept;
  logic              fwd_hit;
  logic [DATA_W-1:0] fwd_data;

`ifdef DM_LSU_FWD_EN
  dm_lsu_fwd_buf u_fwd_buf (
    .clk      (clk),
    .rst_f    (rst_f),
    .upd      (state_q == WR_HOLD),
    .upd_addr (write_addr_q),
    .upd_data (write_data_q),
    .lk_addr  (req_addr),
    .hit      (fwd_hit),
    .hit_data (fwd_data)
  );
`else
  assign fwd_hit  = 1'b0;
  assign fwd_data = '0;
`endif

  // Outputs are registered from the current state, so every visible strobe
  // trails its state by one cycle; req_ready drops on the accepting edge.
  always_comb begin
    accept       = req_valid && req_ready_q;
    state_d      = state_q;
    cnt_d        = cnt_q;
    op_we_d      = op_we_q;
    fwd_d        = fwd_q;
    rsp_data_d   = rsp_data_q;
    read_addr_d  = read_addr_q;
    write_addr_d = write_addr_q;
    write_data_d = write_data_q;
    req_ready_d  = (state_q == IDLE) && !accept;
    rsp_valid_d  = (state_q == RD_CAP)  || ((state_q == ERR) && !op_we_q);
    wr_done_d    = (state_q == WR_HOLD) || ((state_q == ERR) &&  op_we_q);
    rsp_err_d    = (state_q == ERR);
    dm_we_d      = (state_q == WR_PULSE);
    unique case (state_q)
      IDLE: begin
        if (accept) begin
          op_we_d = req_we;
          fwd_d   = 1'b0;
          if (addr_oob(req_addr, MAX_ADDR)) begin
            state_d = ERR;
          end else if (req_we) begin
            write_addr_d = req_addr;
            write_data_d = req_wdata;
            state_d      = WR_SETUP;
          end else if (fwd_hit) begin
            fwd_d   = 1'b1;
            state_d = RD_CAP;
          end else begin
            read_addr_d = req_addr;
            cnt_d       = 3'(RD_LAT - 1);
            state_d     = RD_WAIT;
          end
        end
      end
      RD_WAIT: begin
        if (cnt_q == '0) state_d = RD_CAP;
        else             cnt_d   = cnt_q - 3'd1;
      end
      RD_CAP: begin
        rsp_data_d = fwd_q ? fwd_data : read_data;
        state_d    = IDLE;
      end
      WR_SETUP: begin
        cnt_d   = 3'(WE_CYCLES - 1);
        state_d = WR_PULSE;
      end
      WR_PULSE: begin
        if (cnt_q == '0) state_d = WR_HOLD;
        else             cnt_d   = cnt_q - 3'd1;
      end
      WR_HOLD: state_d = IDLE;
      ERR:     state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_f) begin
    if (!rst_f) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      op_we_q     <= 1'b0;
      fwd_q       <= 1'b0;
      req_ready_q <= 1'b1;
      rsp_valid_q <= 1'b0;
      wr_done_q   <= 1'b0;
      rsp_err_q   <= 1'b0;
      dm_we_q     <= 1'b0;
      rsp_data_q  <= '0;
      read_addr_q <= '0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      op_we_q     <= op_we_d;
      fwd_q       <= fwd_d;
      req_ready_q <= req_ready_d;
      rsp_valid_q <= rsp_valid_d;
      wr_done_q   <= wr_done_d;
      rsp_err_q   <= rsp_err_d;
      dm_we_q     <= dm_we_d;
      rsp_data_q  <= rsp_data_d;
      read_addr_q <= read_addr_d;
    end
  end

  // Store address/data survive reset so a reset-forced dm_we fall still
  // commits the in-flight store to the right word.
  always_ff @(posedge clk) begin
    write_addr_q <= write_addr_d;
    write_data_q <= write_data_d;
  end

  assign req_ready  = req_ready_q;
  assign rsp_valid  = rsp_valid_q;
  assign rsp_data   = rsp_data_q;
  assign wr_done    = wr_done_q;
  assign rsp_err    = rsp_err_q;
  assign read_addr  = read_addr_q;
  assign write_addr = write_addr_q;
  assign write_data = write_data_q;
  assign dm_we      = dm_we_q;

endmodule

// File: tb/tb_dm_lsu.sv
// Directed bench for dm_lsu: default-timing instance backed by a memory model
// committing on dm_we fall, plus an RD_LAT=3 / WE_CYCLES=2 instance.
module tb_dm_lsu;

`ifdef DM_LSU_FWD_EN
  localparam int          HIT_LAT = 1;
  localparam logic [15:0] HIT_RA  = 16'h0000;
`else
  localparam int          HIT_LAT = 2;
  localparam logic [15:0] HIT_RA  = 16'h0010;
`endif

  logic        clk = 1'b0;
  logic        rst_f = 1'b0;
  logic [1:0]  req_valid = '0, req_we = '0;
  logic [1:0]  req_ready, rsp_valid, wr_done, rsp_err, dm_we;
  logic [15:0] req_addr [2];
  logic [31:0] req_wdata [2];
  logic [31:0] rsp_data [2];
  logic [15:0] read_addr [2], write_addr [2];
  logic [31:0] write_data [2];
  logic [31:0] rdata0, rdata1;
  logic [31:0] mem [256];
  int          n_vec = 0, n_err = 0, rises0 = 0;

  always #5 clk = ~clk;

  assign rdata0 = mem[read_addr[0][7:0]];
  assign rdata1 = {16'hA5A5, read_addr[1]};

  always @(negedge dm_we[0]) mem[write_addr[0][7:0]] = write_data[0];
  always @(posedge dm_we[0]) rises0++;

  dm_lsu u_dut (
    .clk(clk), .rst_f(rst_f), .req_valid(req_valid[0]), .req_we(req_we[0]),
    .req_addr(req_addr[0]), .req_wdata(req_wdata[0]), .req_ready(req_ready[0]),
    .rsp_valid(rsp_valid[0]), .rsp_data(rsp_data[0]), .wr_done(wr_done[0]),
    .rsp_err(rsp_err[0]), .read_addr(read_addr[0]), .write_addr(write_addr[0]),
    .write_data(write_data[0]), .dm_we(dm_we[0]), .read_data(rdata0)
  );

  dm_lsu #(.RD_LAT(3), .WE_CYCLES(2)) u_dut2 (
    .clk(clk), .rst_f(rst_f), .req_valid(req_valid[1]), .req_we(req_we[1]),
    .req_addr(req_addr[1]), .req_wdata(req_wdata[1]), .req_ready(req_ready[1]),
    .rsp_valid(rsp_valid[1]), .rsp_data(rsp_data[1]), .wr_done(wr_done[1]),
    .rsp_err(rsp_err[1]), .read_addr(read_addr[1]), .write_addr(write_addr[1]),
    .write_data(write_data[1]), .dm_we(dm_we[1]), .read_data(rdata1)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, got, exp);
    end
  endtask

  task automatic wait_ready(input int d);
    for (int k = 0; k < 50 && !req_ready[d]; k++) begin
      @(posedge clk); #1;
    end
  endtask

  // Issue one request and follow it to its response. Returns the response
  // cycle (edge of acceptance = cycle 0), dm_we-high cycle count, rsp_err,
  // store address/data stability, and the ready/pulse shape after response.
  task automatic run_op(input int d, input logic we, input logic [15:0] addr,
                        input logic [31:0] wd, output int lat, output int hi,
                        output logic err, output logic stable, output logic rdy_ok);
    wait_ready(d);
    req_valid[d] = 1'b1; req_we[d] = we; req_addr[d] = addr; req_wdata[d] = wd;
    @(posedge clk); #1;
    req_valid[d] = 1'b0;
    lat = -1; hi = 0; err = 1'b0; stable = 1'b1; rdy_ok = 1'b0;
    for (int n = 0; n < 24; n++) begin
      if (dm_we[d]) hi++;
      if (write_addr[d] !== addr || write_data[d] !== wd) stable = 1'b0;
      if (rsp_valid[d] || wr_done[d]) begin
        lat = n; err = rsp_err[d];
        break;
      end
      @(posedge clk); #1;
    end
    if (lat >= 0) begin
      rdy_ok = !req_ready[d];
      @(posedge clk); #1;
      rdy_ok = rdy_ok && req_ready[d] && !rsp_valid[d] && !wr_done[d] && !rsp_err[d];
    end
  endtask

  initial begin
    int lat, hi, r0, wdn;
    logic err, stable, rdy_ok;

    for (int i = 0; i < 256; i++) mem[i] = 32'hC000_0000 | 32'(i);
    for (int d = 0; d < 2; d++) begin
      req_addr[d] = '0; req_wdata[d] = '0;
    end

    repeat (3) @(posedge clk);
    #1;
    chk("rst_req_ready", 32'(req_ready[0]), 32'd1);
    chk("rst_rsp_valid", 32'(rsp_valid[0]), 32'd0);
    chk("rst_wr_done",   32'(wr_done[0]),   32'd0);
    chk("rst_rsp_err",   32'(rsp_err[0]),   32'd0);
    chk("rst_dm_we",     32'(dm_we[0]),     32'd0);
    chk("rst_rsp_data",  rsp_data[0],       32'h0);
    chk("rst_read_addr", 32'(read_addr[0]), 32'h0);
    @(negedge clk) rst_f = 1'b1;
    @(posedge clk); #1;

    // Store DEADBEEF @0x0010
    run_op(0, 1'b1, 16'h0010, 32'hDEADBEEF, lat, hi, err, stable, rdy_ok);
    chk("st_wr_done_cycle", 32'(lat), 32'd3);
    chk("st_we_cycles",     32'(hi),  32'd1);
    chk("st_err",           32'(err), 32'd0);
    chk("st_addr_stable",   32'(stable), 32'd1);
    chk("st_ready_shape",   32'(rdy_ok), 32'd1);
    chk("st_mem_0010",      mem[8'h10], 32'hDEADBEEF);

    // Load back the stored word
    run_op(0, 1'b0, 16'h0010, 32'h0, lat, hi, err, stable, rdy_ok);
    chk("ld_hit_cycle",  32'(lat), 32'(HIT_LAT));
    chk("ld_hit_data",   rsp_data[0], 32'hDEADBEEF);
    chk("ld_hit_err",    32'(err), 32'd0);
    chk("ld_hit_raddr",  32'(read_addr[0]), 32'(HIT_RA));
    chk("ld_hit_ready",  32'(rdy_ok), 32'd1);

    // Load from an unwritten word
    run_op(0, 1'b0, 16'h0020, 32'h0, lat, hi, err, stable, rdy_ok);
    chk("ld_0020_cycle", 32'(lat), 32'd2);
    chk("ld_0020_data",  rsp_data[0], 32'hC0000020);
    chk("ld_0020_raddr", 32'(read_addr[0]), 32'h0020);

    // Out-of-range load and store
    r0 = rises0;
    run_op(0, 1'b0, 16'hFFFE, 32'h0, lat, hi, err, stable, rdy_ok);
    chk("ld_oob_cycle", 32'(lat), 32'd1);
    chk("ld_oob_err",   32'(err), 32'd1);
    chk("ld_oob_vld",   32'(rsp_valid[0] | wr_done[0]), 32'd0);
    chk("ld_oob_data",  rsp_data[0], 32'hC0000020);
    chk("ld_oob_raddr", 32'(read_addr[0]), 32'h0020);
    chk("ld_oob_ready", 32'(rdy_ok), 32'd1);
    run_op(0, 1'b1, 16'hFFFF, 32'h55AA55AA, lat, hi, err, stable, rdy_ok);
    chk("st_oob_cycle", 32'(lat), 32'd1);
    chk("st_oob_err",   32'(err), 32'd1);
    chk("st_oob_we",    32'(rises0 - r0), 32'd0);
    chk("st_oob_ready", 32'(rdy_ok), 32'd1);

    // Store with request held until ready returns
    wait_ready(0);
    r0 = rises0; wdn = 0; lat = -1;
    req_valid[0] = 1'b1; req_we[0] = 1'b1; req_addr[0] = 16'h0008; req_wdata[0] = 32'h11111111;
    @(posedge clk); #1;
    for (int n = 0; n < 20; n++) begin
      if (wr_done[0]) wdn++;
      if (req_ready[0]) begin lat = n; break; end
      @(posedge clk); #1;
    end
    req_valid[0] = 1'b0;
    repeat (6) begin
      @(posedge clk); #1;
      if (wr_done[0]) wdn++;
    end
    chk("hold_ready_cycle", 32'(lat), 32'd4);
    chk("hold_we_rises",    32'(rises0 - r0), 32'd1);
    chk("hold_wr_done",     32'(wdn), 32'd1);
    chk("hold_mem_0008",    mem[8'h08], 32'h11111111);

    // Reset during the write pulse
    wait_ready(0);
    req_valid[0] = 1'b1; req_we[0] = 1'b1; req_addr[0] = 16'h0004; req_wdata[0] = 32'h12345678;
    @(posedge clk); #1;
    req_valid[0] = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("rstp_we_high", 32'(dm_we[0]), 32'd1);
    #2 rst_f = 1'b0;
    #1;
    chk("rstp_we_low",   32'(dm_we[0]), 32'd0);
    chk("rstp_mem_0004", mem[8'h04], 32'h12345678);
    chk("rstp_ready",    32'(req_ready[0]), 32'd1);
    @(posedge clk);
    @(negedge clk) rst_f = 1'b1;
    @(posedge clk); #1;
    run_op(0, 1'b0, 16'h0004, 32'h0, lat, hi, err, stable, rdy_ok);
    chk("rstp_ld_cycle", 32'(lat), 32'd2);
    chk("rstp_ld_data",  rsp_data[0], 32'h12345678);

    // Slow-timing instance
    run_op(1, 1'b0, 16'h0030, 32'h0, lat, hi, err, stable, rdy_ok);
    chk("lat3_ld_cycle", 32'(lat), 32'd4);
    chk("lat3_ld_data",  rsp_data[1], 32'hA5A50030);
    chk("lat3_ld_ready", 32'(rdy_ok), 32'd1);
    run_op(1, 1'b1, 16'h0040, 32'h0BADF00D, lat, hi, err, stable, rdy_ok);
    chk("we2_done_cycle", 32'(lat), 32'd4);
    chk("we2_we_cycles",  32'(hi), 32'd2);
    chk("we2_stable",     32'(stable), 32'd1);
    chk("we2_ready",      32'(rdy_ok), 32'd1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete, expected finish before 200000");
    $fatal(1);
  end

endmodule
